// File: rtl/counter_seq_arbiter_pkg.sv
// Shared constants for the counter sequencing arbiter: counter4b mode
// encodings, FSM state encoding and the default counter width.
package counter_seq_arbiter_pkg;

   localparam int DEF_WIDTH = 4;

   localparam logic [1:0] MODO_UP1  = 2'b00;
   localparam logic [1:0] MODO_DN1  = 2'b01;
   localparam logic [1:0] MODO_UP3  = 2'b10;
   localparam logic [1:0] MODO_LOAD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/counter_seq_arbiter_arb.sv
// Two-way round-robin arbiter. Purely combinational: i_ptr=0 favours
// requester 0 when both request, i_ptr=1 favours requester 1. A lone
// request always wins regardless of the pointer.
module rr_arbiter2
   import counter_seq_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_ptr,
   output logic [1:0] o_gnt
);

   // one-hot grant from request pattern and priority pointer
   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = i_ptr ? 2'b10 : 2'b01;
         default: o_gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/counter_seq_arbiter.sv
// Shares one counter4b between two requesters. The arbiter picks a winner,
// the FSM loads the start value, runs N count cycles, then reports the final
// Q, the number of RCO wraps seen and whether LOAD failed to confirm.
module counter_seq_arbiter
   import counter_seq_arbiter_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STEP_W = 8,
   parameter int WRAP_W = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [1:0]            req,
   input  logic [3:0]            req_mode,
   input  logic [2*WIDTH-1:0]    req_start,
   input  logic [2*STEP_W-1:0]   req_steps,
   output logic [1:0]            grant,
   output logic [1:0]            done,
   output logic [WIDTH-1:0]      result_q,
   output logic [WRAP_W-1:0]     result_wraps,
   output logic                  result_err,
   output logic                  ENABLE,
   output logic [1:0]            MODO,
   output logic [WIDTH-1:0]      D,
   input  logic [WIDTH-1:0]      Q,
   input  logic                  RCO,
   input  logic                  LOAD
);

   state_t              r_state;
   state_t              w_next;
   logic [1:0]          r_grant;
   logic                r_ptr;
   logic [WIDTH-1:0]    r_start;
   logic [1:0]          r_mode;
   logic [STEP_W-1:0]   r_steps;
   logic [STEP_W-1:0]   r_rem;
   logic                r_first;
   logic [WRAP_W-1:0]   r_wraps;
   logic                r_err;
   logic [WIDTH-1:0]    r_res_q;
   logic [WRAP_W-1:0]   r_res_wraps;
   logic                r_res_err;

   logic [1:0]          w_arb_gnt;
   logic                w_sel;
   logic                w_req_g;
   logic [WRAP_W-1:0]   w_wraps_fin;

   // Saturating increment: the wrap count sticks at all-ones.
   function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v,
                                                 input logic inc);
      if (inc && (v != {WRAP_W{1'b1}}))
         return v + WRAP_W'(1);
      return v;
   endfunction

   rr_arbiter2 u_arb (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt)
   );

   assign w_sel       = w_arb_gnt[1];
   assign w_req_g     = |(req & r_grant);
   assign w_wraps_fin = sat_inc(r_wraps, RCO);
   assign grant       = r_grant;

   // state register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // next state, counter pins, done pulse and result presentation
   always_comb begin
      w_next       = r_state;
      ENABLE       = 1'b0;
      MODO         = MODO_UP1;
      D            = '0;
      done         = 2'b00;
      result_q     = r_res_q;
      result_wraps = r_res_wraps;
      result_err   = r_res_err;
      case (r_state)
         ST_IDLE: begin
            if (|req) w_next = ST_LOAD;
         end
         ST_LOAD: begin
            ENABLE = 1'b1;
            MODO   = MODO_LOAD;
            D      = r_start;
            if (!w_req_g)
               w_next = ST_IDLE;
            else if ((r_mode == MODO_LOAD) || (r_steps == '0))
               w_next = ST_DONE;
            else
               w_next = ST_RUN;
         end
         ST_RUN: begin
            ENABLE = 1'b1;
            MODO   = r_mode;
            D      = r_start;
            // remaining==0 is unreachable but still exits rather than wrapping
            if (!w_req_g)
               w_next = ST_IDLE;
            else if (r_rem <= STEP_W'(1))
               w_next = ST_DONE;
         end
         ST_DONE: begin
            done         = r_grant;
            result_q     = Q;
            result_wraps = w_wraps_fin;
            result_err   = r_err;
            w_next       = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // command latch at grant time; data only, no reset needed
   always_ff @(posedge CLK) begin
      if ((r_state == ST_IDLE) && (|req)) begin
         r_start <= w_sel ? req_start[2*WIDTH-1:WIDTH]   : req_start[WIDTH-1:0];
         r_mode  <= w_sel ? req_mode[3:2]                : req_mode[1:0];
         r_steps <= w_sel ? req_steps[2*STEP_W-1:STEP_W] : req_steps[STEP_W-1:0];
      end
   end

   // grant, pointer, step/wrap/error tracking and held results
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_grant     <= 2'b00;
         r_ptr       <= 1'b0;
         r_rem       <= '0;
         r_first     <= 1'b0;
         r_wraps     <= '0;
         r_err       <= 1'b0;
         r_res_q     <= '0;
         r_res_wraps <= '0;
         r_res_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|req) r_grant <= w_arb_gnt;
            end
            ST_LOAD: begin
               r_wraps <= '0;
               r_err   <= 1'b0;
               r_rem   <= r_steps;
               r_first <= 1'b1;
               if (!w_req_g) begin
                  r_grant <= 2'b00;
                  r_ptr   <= r_grant[0];
               end
            end
            ST_RUN: begin
               r_first <= 1'b0;
               if (r_rem != '0) r_rem <= r_rem - STEP_W'(1);
               // first RUN cycle must see the counter confirm the load;
               // its RCO reflects the load itself, so it is not a wrap
               if (r_first && !LOAD) r_err <= 1'b1;
               if (!r_first) r_wraps <= sat_inc(r_wraps, RCO);
               if (!w_req_g) begin
                  r_grant <= 2'b00;
                  r_ptr   <= r_grant[0];
               end
            end
            ST_DONE: begin
               r_res_q     <= Q;
               r_res_wraps <= w_wraps_fin;
               r_res_err   <= r_err;
               r_grant     <= 2'b00;
               r_ptr       <= r_grant[0];
            end
            default: r_grant <= 2'b00;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_seq_arbiter.sv
// Bench for counter_seq_arbiter: a behavioural counter4b drives Q/RCO/LOAD,
// a scoreboard queue holds expected results per transaction, and a monitor
// pops and compares on every done pulse.
module tb_counter_seq_arbiter;
   import counter_seq_arbiter_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [1:0]  req;
   logic [3:0]  req_mode;
   logic [7:0]  req_start;
   logic [15:0] req_steps;
   logic [1:0]  grant, done;
   logic [3:0]  result_q, result_wraps;
   logic        result_err;
   logic        ENABLE;
   logic [1:0]  MODO;
   logic [3:0]  D, Q;
   logic        RCO, LOAD;

   logic [3:0]  cq;
   logic        crco, cload;
   logic        noload;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int en_cnt = 0;
   int k;

   typedef struct {
      logic [1:0] id;
      logic [3:0] q;
      logic [3:0] w;
      logic       e;
      int         cyc;
      int         en;
   } exp_t;
   exp_t sb[$];

   counter_seq_arbiter dut (
      .CLK(CLK), .RESET(RESET), .req(req), .req_mode(req_mode),
      .req_start(req_start), .req_steps(req_steps), .grant(grant),
      .done(done), .result_q(result_q), .result_wraps(result_wraps),
      .result_err(result_err), .ENABLE(ENABLE), .MODO(MODO), .D(D),
      .Q(Q), .RCO(RCO), .LOAD(LOAD)
   );

   always #5 CLK = ~CLK;

   // behavioural counter4b: registered Q, RCO on wrap, LOAD after a load
   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cq <= 4'h0; crco <= 1'b0; cload <= 1'b0;
      end else if (ENABLE) begin
         cload <= (MODO == MODO_LOAD);
         case (MODO)
            MODO_LOAD: begin cq <= D; crco <= 1'b0; end
            MODO_UP1:  {crco, cq} <= {1'b0, cq} + 5'd1;
            MODO_DN1:  begin cq <= cq - 4'd1; crco <= (cq == 4'h0); end
            default:   {crco, cq} <= {1'b0, cq} + 5'd3;
         endcase
      end else begin
         crco <= 1'b0; cload <= 1'b0;
      end
   end
   assign Q    = cq;
   assign RCO  = crco;
   assign LOAD = cload & ~noload;

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic void ref_run(input logic [3:0] st, input logic [1:0] md, input int ns,
                                   output logic [3:0] q, output logic [3:0] w);
      logic [4:0] s;
      q = st; w = 4'h0;
      if (md != MODO_LOAD) begin
         for (int i = 0; i < ns; i++) begin
            case (md)
               MODO_UP1: s = {1'b0, q} + 5'd1;
               MODO_DN1: s = {1'b0, q} - 5'd1;
               default:  s = {1'b0, q} + 5'd3;
            endcase
            q = s[3:0];
            if (s[4] && (w != 4'hF)) w = w + 4'h1;
         end
      end
   endfunction

   function automatic int lat(input logic [1:0] md, input int ns);
      return ((md == MODO_LOAD) || (ns == 0)) ? 2 : ns + 2;
   endfunction

   task automatic cmd(input int id, input logic [3:0] st, input logic [1:0] md, input int ns);
      req_start[id*4 +: 4] = st;
      req_mode[id*2 +: 2]  = md;
      req_steps[id*8 +: 8] = ns[7:0];
   endtask

   task automatic push_exp(input int id, input logic [3:0] st, input logic [1:0] md, input int ns,
                           input logic fe, input int cyc_exp);
      exp_t e;
      logic [3:0] q, w;
      ref_run(st, md, ns, q, w);
      e.id  = (id == 0) ? 2'b01 : 2'b10;
      e.q   = q;
      e.w   = w;
      e.e   = fe && (md != MODO_LOAD) && (ns != 0);
      e.cyc = cyc_exp;
      e.en  = ((md == MODO_LOAD) || (ns == 0)) ? 1 : ns + 1;
      sb.push_back(e);
   endtask

   // raise the requested bits, drop each when its done arrives, bounded wait
   task automatic serve(input logic [1:0] mask);
      logic [1:0] pend;
      int n;
      pend = mask;
      req  = req | mask;
      n    = 0;
      while ((pend != 2'b00) && (n < 400)) begin
         @(negedge CLK);
         pend = pend & ~done;
         req  = req & ~done;
         n++;
      end
      if (pend != 2'b00) begin
         chk("timeout", {30'd0, pend}, 32'd0);
         req = 2'b00;
      end
      @(negedge CLK);
   endtask

   // monitor: ENABLE cycle count per transaction and scoreboard compare
   initial forever begin
      exp_t e;
      @(negedge CLK);
      if ((grant == 2'b00) && !ENABLE) en_cnt = 0;
      else if (ENABLE) en_cnt++;
      if (done != 2'b00) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", {30'd0, done}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("done_id",  {30'd0, done}, {30'd0, e.id});
            chk("grant_at_done", {30'd0, grant}, {30'd0, e.id});
            chk("result_q", {28'd0, result_q}, {28'd0, e.q});
            chk("result_wraps", {28'd0, result_wraps}, {28'd0, e.w});
            chk("result_err", {31'd0, result_err}, {31'd0, e.e});
            chk("done_cycle", cyc, e.cyc);
            chk("enable_cycles", en_cnt, e.en);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b0; req = 2'b00; req_mode = 4'h0; req_start = 8'h00;
      req_steps = 16'h0000; noload = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_enable", {31'd0, ENABLE}, 32'd0);
      chk("rst_grant",  {30'd0, grant}, 32'd0);
      chk("rst_done",   {30'd0, done}, 32'd0);
      chk("rst_modo",   {30'd0, MODO}, 32'd0);
      chk("rst_d",      {28'd0, D}, 32'd0);
      chk("rst_res",    {23'd0, result_q, result_wraps, result_err}, 32'd0);
      RESET = 1'b1;
      @(negedge CLK);

      // up-count through a wrap
      cmd(0, 4'hE, MODO_UP1, 3); k = cyc;
      push_exp(0, 4'hE, MODO_UP1, 3, 1'b0, k + 5);
      serve(2'b01);

      // up-by-3 on requester 1
      cmd(1, 4'h0, MODO_UP3, 6); k = cyc;
      push_exp(1, 4'h0, MODO_UP3, 6, 1'b0, k + 8);
      serve(2'b10);

      // simultaneous: requester 0 first
      cmd(0, 4'h5, MODO_UP1, 2); cmd(1, 4'h3, MODO_DN1, 4); k = cyc;
      push_exp(0, 4'h5, MODO_UP1, 2, 1'b0, k + lat(MODO_UP1, 2));
      push_exp(1, 4'h3, MODO_DN1, 4, 1'b0, k + lat(MODO_UP1, 2) + 1 + lat(MODO_DN1, 4));
      serve(2'b11);

      // load-only
      cmd(0, 4'h9, MODO_LOAD, 5); k = cyc;
      push_exp(0, 4'h9, MODO_LOAD, 5, 1'b0, k + 2);
      serve(2'b01);

      // simultaneous again: requester 1 first now
      cmd(0, 4'h1, MODO_DN1, 1); cmd(1, 4'hF, MODO_UP1, 1); k = cyc;
      push_exp(1, 4'hF, MODO_UP1, 1, 1'b0, k + lat(MODO_UP1, 1));
      push_exp(0, 4'h1, MODO_DN1, 1, 1'b0, k + lat(MODO_UP1, 1) + 1 + lat(MODO_DN1, 1));
      serve(2'b11);

      // LOAD never confirmed -> error, then a clean transaction clears it
      noload = 1'b1;
      cmd(1, 4'h2, MODO_UP1, 2); k = cyc;
      push_exp(1, 4'h2, MODO_UP1, 2, 1'b1, k + 4);
      serve(2'b10);
      noload = 1'b0;
      cmd(1, 4'h4, MODO_UP3, 1); k = cyc;
      push_exp(1, 4'h4, MODO_UP3, 1, 1'b0, k + 3);
      serve(2'b10);

      // wrap count saturation, then steps=0
      cmd(0, 4'h0, MODO_UP3, 100); k = cyc;
      push_exp(0, 4'h0, MODO_UP3, 100, 1'b0, k + 102);
      serve(2'b01);
      cmd(1, 4'h6, MODO_UP1, 0); k = cyc;
      push_exp(1, 4'h6, MODO_UP1, 0, 1'b0, k + 2);
      serve(2'b10);

      // abort mid-RUN: no done, results held, pointer advances
      cmd(0, 4'h0, MODO_UP1, 10);
      req[0] = 1'b1;
      repeat (4) @(negedge CLK);
      req[0] = 1'b0;
      @(negedge CLK);
      chk("abort_enable", {31'd0, ENABLE}, 32'd0);
      chk("abort_grant",  {30'd0, grant}, 32'd0);
      chk("abort_done",   {30'd0, done}, 32'd0);
      chk("abort_res",    {23'd0, result_q, result_wraps, result_err}, {23'd0, 4'h6, 4'h0, 1'b0});
      @(negedge CLK);
      cmd(0, 4'h3, MODO_UP1, 1); cmd(1, 4'h8, MODO_UP1, 2); k = cyc;
      push_exp(1, 4'h8, MODO_UP1, 2, 1'b0, k + lat(MODO_UP1, 2));
      push_exp(0, 4'h3, MODO_UP1, 1, 1'b0, k + lat(MODO_UP1, 2) + 1 + lat(MODO_UP1, 1));
      serve(2'b11);

      // asynchronous reset mid-RUN
      cmd(0, 4'h0, MODO_UP1, 10);
      req[0] = 1'b1;
      repeat (4) @(negedge CLK);
      #2 RESET = 1'b0;
      #1;
      chk("arst_enable", {31'd0, ENABLE}, 32'd0);
      chk("arst_grant",  {30'd0, grant}, 32'd0);
      chk("arst_modo_d", {26'd0, MODO, D}, 32'd0);
      chk("arst_res",    {23'd0, result_q, result_wraps, result_err}, 32'd0);
      req = 2'b00;
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      cmd(0, 4'h1, MODO_UP1, 1); cmd(1, 4'h2, MODO_UP1, 1); k = cyc;
      push_exp(0, 4'h1, MODO_UP1, 1, 1'b0, k + lat(MODO_UP1, 1));
      push_exp(1, 4'h2, MODO_UP1, 1, 1'b0, k + lat(MODO_UP1, 1) + 1 + lat(MODO_UP1, 1));
      serve(2'b11);

      repeat (3) @(negedge CLK);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_seq_arbiter.md
Name: counter_seq_arbiter

Overview:
- Controller that shares one counter4b instance between two requesters.
- Each requester submits a command: start value, counting mode and step count.
- A round-robin arbiter grants the counter. An FSM sequences the counter through a parallel load followed by N enabled count cycles, then returns the final Q, an RCO (wrap) count and a LOAD-check error to the winning requester.
- Sits between the requester logic and the counter4b pins ENABLE/MODO/D/Q/RCO/LOAD.

Parameters:
- WIDTH, 4, counter data width (matches counter4b).
- STEP_W, 8, width of the step-count field.
- WRAP_W, 4, width of the saturating RCO counter in the result.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- req  input  2  per-requester request level; bit i = requester i.
- req_mode  input  4  2 bits per requester; {req_mode[3:2]} belongs to requester 1.
- req_start  input  2*WIDTH  per-requester load value.
- req_steps  input  2*STEP_W  per-requester count-cycle count.
- grant  output  2  one-hot; identifies the requester owning the counter.
- done  output  2  one-cycle completion pulse to the granted requester.
- result_q  output  WIDTH  counter Q captured at completion.
- result_wraps  output  WRAP_W  number of sampled RCO=1 cycles, saturating at all-ones.
- result_err  output  1  counter LOAD not seen after the load cycle.
- ENABLE  output  1  to counter4b ENABLE.
- MODO  output  2  to counter4b MODO.
- D  output  WIDTH  to counter4b D.
- Q  input  WIDTH  from counter4b Q.
- RCO  input  1  from counter4b RCO.
- LOAD  input  1  from counter4b LOAD.

Behaviour:
- Counter mode encoding:
  - 00 = up by 1.
  - 01 = down by 1.
  - 10 = up by 3.
  - 11 = parallel load of D.
- Reset (RESET=0, asynchronous):
  - state=IDLE.
  - grant, done, ENABLE, MODO, D, result_q, result_wraps and result_err all 0.
  - Round-robin pointer favours requester 0.
- Handshake:
  - A requester holds req high with stable command fields until its done pulse.
  - Fields are latched at grant.
  - Keeping req high after done is a new request.
- IDLE:
  - ENABLE=0.
  - If any req bit is set, grant the requester per the round-robin rule, latch its command, go to LOAD.
  - On simultaneous requests, grant the requester not granted last.
  - A single request is granted immediately.
- LOAD (1 cycle):
  - ENABLE=1, MODO=11, D=latched start.
  - Clear wrap count and error.
  - If latched mode=11 or steps=0, go to DONE; otherwise go to RUN with remaining=steps.
- RUN:
  - ENABLE=1, MODO=latched mode; decrement remaining each cycle.
  - In the first RUN cycle, LOAD must be 1; otherwise set err.
  - In every RUN cycle except the first, RCO=1 increments wraps.
  - When remaining==1, go to DONE.
- DONE (1 cycle):
  - ENABLE=0; done[g]=1.
  - result_q=Q.
  - If RCO=1, also count it into result_wraps before output.
  - result_err=err.
  - Clear grant, advance the pointer past g, go to IDLE.
  - Result outputs hold their value until the next DONE.
- grant stays stable from LOAD through DONE inclusive.
- Latency: req first seen in IDLE at cycle t gives LOAD at t+1, RUN at t+2..t+1+N, and done at t+2+N. With steps=0 or mode=11, done comes at t+2.
- Abort: if req[g] falls during LOAD or RUN, go to IDLE next cycle with ENABLE=0. No done pulse, results unchanged, pointer still advances.
- The wrap counter saturates and never wraps.
- remaining never underflows.

Decomposition:
- Shared package holds:
  - Mode constants MODO_UP1/MODO_DN1/MODO_UP3/MODO_LOAD.
  - FSM state encoding ST_IDLE/ST_LOAD/ST_RUN/ST_DONE.
  - Default WIDTH.
- One natural sub-module: rr_arbiter2, which takes req and pointer and returns a one-hot grant combinationally.
- The FSM and datapath stay in the top module.

Test Plan:
- Up-count wrap: after reset, req0 with start=0xE, mode=00, steps=3 → Q sequence 0xE,0xF,0x0,0x1; done[0] at t+5; result_q=0x1, result_wraps=1, result_err=0.
- Up-by-3: req1 with start=0x0, mode=10, steps=6 → done[1] at t+8, result_q=0x2; ENABLE high for exactly 7 cycles.
- Simultaneous requests: req=11 at the same cycle after reset → requester 0 completes first, then requester 1; a second simultaneous pair serves requester 1 first.
- Load only: req0 with mode=11, start=0x9, steps=5 → LOAD only, done[0] at t+2, result_q=0x9.
- Abort and reset: req0 falls mid-RUN → IDLE next cycle with no done; RESET pulsed low mid-RUN → ENABLE, grant and outputs 0 immediately, and the next simultaneous request grants requester 0.
- Error: force LOAD=0 after the load cycle → result_err=1 with done asserted normally.
